// File: rtl/imem_loader.sv
// Loads a framed byte stream into instruction RAM as big-endian words and holds the CPU in reset
// until a full image has landed. Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter int unsigned ADDR_W      = 10,
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              in_RST,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned       CntW     = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned       MaxWords = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] Base     = ADDR_W'(BASE_ADDR);
  localparam logic [CntW-1:0]   IdleLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StWrite,
`ifdef LOADER_CHECKSUM_EN
    StCheck,
`endif
    StDone,
    StError
  } state_e;

  state_e          state_q;
  logic [7:0]      len_hi_q;
  logic [15:0]     len_q;
  logic [23:0]     word_q;
  logic [1:0]      byte_idx_q;
  logic [CntW-1:0] idle_cnt_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  logic        fire;
  logic        counting;
  logic        timed_out;
  logic [15:0] len_rx;

  assign fire      = rx_valid & rx_ready;
  assign timed_out = (idle_cnt_q == IdleLast);
  assign len_rx    = {len_hi_q, rx_data};

  always_comb begin
    counting = 1'b0;
    case (state_q)
      StLenHi, StLenLo, StData: counting = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      StCheck:                  counting = 1'b1;
`endif
      default:                  counting = 1'b0;
    endcase
  end

  // rx_ready is registered from the next state: every transition into WRITE, DONE or ERROR drops it.
  always_ff @(posedge clk or posedge in_RST) begin
    if (in_RST) begin
      state_q      <= StIdle;
      rx_ready     <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= Base;
      im_wdata     <= '0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      len_hi_q     <= '0;
      len_q        <= '0;
      word_q       <= '0;
      byte_idx_q   <= '0;
      idle_cnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      im_we      <= 1'b0;
      rx_ready   <= 1'b1;
      idle_cnt_q <= '0;
      case (state_q)
        StIdle: begin
          if (fire && rx_data == HEADER) begin
            state_q      <= StLenHi;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            byte_idx_q   <= '0;
            cpu_hold     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
          end
        end
        StLenHi: begin
          if (fire) begin
            len_hi_q <= rx_data;
            state_q  <= StLenLo;
          end
        end
        StLenLo: begin
          if (fire) begin
            len_q <= len_rx;
            if (len_rx == 16'd0 || 32'(len_rx) > MaxWords) begin
              state_q  <= StError;
              rx_ready <= 1'b0;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (fire) begin
            word_q     <= {word_q[15:0], rx_data};
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ rx_data;
`endif
            if (byte_idx_q == 2'd3) begin
              state_q      <= StWrite;
              rx_ready     <= 1'b0;
              im_we        <= 1'b1;
              im_wdata     <= {word_q, rx_data};
              im_addr      <= Base + words_loaded[ADDR_W-1:0];
              words_loaded <= words_loaded + {{ADDR_W{1'b0}}, 1'b1};
            end
          end
        end
        StWrite: begin
          // words_loaded already counts the word written in this cycle.
          if (16'(words_loaded) == len_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_q  <= StCheck;
`else
            state_q  <= StDone;
            rx_ready <= 1'b0;
`endif
          end else begin
            state_q <= StData;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        StCheck: begin
          if (fire) begin
            state_q  <= (rx_data == csum_q) ? StDone : StError;
            rx_ready <= 1'b0;
          end
        end
`endif
        StDone: begin
          load_done <= 1'b1;
          cpu_hold  <= 1'b0;
          state_q   <= StIdle;
        end
        StError: begin
          load_err <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (counting && !fire) begin
        if (timed_out) begin
          state_q  <= StError;
          rx_ready <= 1'b0;
        end else begin
          idle_cnt_q <= idle_cnt_q + {{(CntW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader; expected writes come from the frame contents.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 10;
  localparam logic [7:0]  HDR    = 8'hA5;
  localparam int unsigned BASE   = 1;
  localparam int unsigned TMO    = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk      = 1'b0;
  logic              in_RST   = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data  = 8'h00;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(
    .ADDR_W     (ADDR_W),
    .HEADER     (HDR),
    .BASE_ADDR  (BASE),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk         (clk),
    .in_RST      (in_RST),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .im_we       (im_we),
    .im_addr     (im_addr),
    .im_wdata    (im_wdata),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done),
    .load_err    (load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0]       pay[$];
  logic [ADDR_W-1:0] wq_a[$];
  logic [31:0]       wq_d[$];

  // Every cycle with im_we high is one RAM write.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wq_a.push_back(im_addr);
      wq_d.push_back(im_wdata);
    end
  end

  function automatic logic [ADDR_W-1:0] exp_addr(input int idx);
    return ADDR_W'((BASE + idx) % DEPTH);
  endfunction

  // Called and returning at a negedge; the transfer happens on the posedge in between.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake: rx_ready=%b after %0d cycles, required 1", rx_ready, guard);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    logic [15:0] n;
    n = 16'(pay.size());
    send_byte(HDR, gaps);
    send_byte(n[15:8], gaps);
    send_byte(n[7:0], gaps);
    foreach (pay[i]) begin
      for (int k = 3; k >= 0; k--) send_byte(pay[i][8*k +: 8], gaps);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic send_csum(input bit corrupt);
    logic [7:0] cs = 8'h00;
    foreach (pay[i]) cs = cs ^ pay[i][31:24] ^ pay[i][23:16] ^ pay[i][15:8] ^ pay[i][7:0];
    send_byte(corrupt ? (cs ^ 8'h01) : cs, 1'b0);
  endtask
`endif

  task automatic wait_end(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (load_done === 1'b1 || load_err === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_hold: got %b want 1", cpu_hold); end
    checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", im_we); end
    checks++;
    if (im_addr !== ADDR_W'(BASE)) begin
      errors++; $display("FAIL rst_addr: got %h want %h", im_addr, ADDR_W'(BASE));
    end
    checks++; if (im_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", im_wdata); end
    checks++;
    if (load_done !== 1'b0 || load_err !== 1'b0) begin
      errors++; $display("FAIL rst_flags: got done=%b err=%b want 0 0", load_done, load_err);
    end
    checks++;
    if (words_loaded !== '0) begin errors++; $display("FAIL rst_words: got %0d want 0", words_loaded); end
    in_RST = 1'b0;
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0: got %b want 0", rx_ready); end
    @(negedge clk);
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready1: got %b want 1", rx_ready); end
  endtask

  task automatic test_basic;
    bit seen;
    pay = '{32'h0000000D, 32'h24080001};
    wq_a.delete(); wq_d.delete();
    send_frame(1'b0);
`ifdef LOADER_CHECKSUM_EN
    send_csum(1'b0);
`endif
    wait_end(seen);
    checks++; if (!seen) begin errors++; $display("FAIL basic_end: no done/err, want done"); end
    checks++;
    if (load_done !== 1'b1 || load_err !== 1'b0) begin
      errors++; $display("FAIL basic_flags: got done=%b err=%b want 1 0", load_done, load_err);
    end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL basic_hold: got %b want 0", cpu_hold); end
    checks++;
    if (words_loaded !== 11'd2) begin errors++; $display("FAIL basic_words: got %0d want 2", words_loaded); end
    checks++;
    if (wq_a.size() != 2) begin errors++; $display("FAIL basic_nwr: got %0d want 2", wq_a.size()); end
    for (int i = 0; i < wq_a.size() && i < 2; i++) begin
      checks++;
      if (wq_a[i] !== exp_addr(i) || wq_d[i] !== pay[i]) begin
        errors++;
        $display("FAIL basic_wr%0d: got %h:%h want %h:%h", i, wq_a[i], wq_d[i], exp_addr(i), pay[i]);
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_csum;
    bit seen;
    pay = '{32'h0000000D, 32'h24080001};
    wq_a.delete(); wq_d.delete();
    send_frame(1'b0);
    send_csum(1'b1);
    wait_end(seen);
    checks++; if (!seen) begin errors++; $display("FAIL csum_end: no done/err, want err"); end
    checks++;
    if (load_done !== 1'b0 || load_err !== 1'b1) begin
      errors++; $display("FAIL csum_flags: got done=%b err=%b want 0 1", load_done, load_err);
    end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL csum_hold: got %b want 1", cpu_hold); end
    checks++;
    if (wq_a.size() != 2) begin errors++; $display("FAIL csum_nwr: got %0d want 2", wq_a.size()); end
  endtask
`endif

  task automatic test_back_to_back;
    bit seen;
    for (int f = 0; f < 2; f++) begin
      pay.delete();
      repeat ($urandom_range(1, 5)) pay.push_back($urandom);
      wq_a.delete(); wq_d.delete();
      send_frame(1'b0);
`ifdef LOADER_CHECKSUM_EN
      send_csum(1'b0);
`endif
      wait_end(seen);
      checks++;
      if (!seen || load_done !== 1'b1) begin
        errors++; $display("FAIL b2b_done%0d: got %b want 1", f, load_done);
      end
      checks++;
      if (wq_a.size() != pay.size()) begin
        errors++; $display("FAIL b2b_nwr%0d: got %0d want %0d", f, wq_a.size(), pay.size());
      end
      for (int i = 0; i < wq_a.size() && i < pay.size(); i++) begin
        checks++;
        if (wq_a[i] !== exp_addr(i) || wq_d[i] !== pay[i]) begin
          errors++;
          $display("FAIL b2b_wr%0d: got %h:%h want %h:%h", i, wq_a[i], wq_d[i], exp_addr(i), pay[i]);
        end
      end
    end
  endtask

  task automatic test_bad_length;
    bit seen;
    logic [7:0] zero_len[5];
    logic [7:0] big_len[3];
    zero_len = '{8'h00, 8'hFF, HDR, 8'h00, 8'h00};
    big_len  = '{HDR, 8'h04, 8'h01};
    wq_a.delete(); wq_d.delete();
    foreach (zero_len[i]) send_byte(zero_len[i], 1'b0);
    wait_end(seen);
    checks++;
    if (!seen || load_err !== 1'b1 || load_done !== 1'b0) begin
      errors++; $display("FAIL len0_flags: got done=%b err=%b want 0 1", load_done, load_err);
    end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL len0_hold: got %b want 1", cpu_hold); end
    checks++;
    if (words_loaded !== '0) begin errors++; $display("FAIL len0_words: got %0d want 0", words_loaded); end
    foreach (big_len[i]) send_byte(big_len[i], 1'b0);
    wait_end(seen);
    checks++;
    if (!seen || load_err !== 1'b1) begin errors++; $display("FAIL len1025_err: got %b want 1", load_err); end
    checks++;
    if (wq_a.size() != 0) begin errors++; $display("FAIL badlen_nwr: got %0d want 0", wq_a.size()); end
  endtask

  task automatic test_timeout;
    bit seen;
    logic [7:0] part[5];
    part = '{HDR, 8'h00, 8'h01, 8'h12, 8'h34};
    wq_a.delete(); wq_d.delete();
    foreach (part[i]) send_byte(part[i], 1'b0);
    wait_end(seen);
    checks++;
    if (!seen || load_err !== 1'b1 || load_done !== 1'b0) begin
      errors++; $display("FAIL tmo_flags: got done=%b err=%b want 0 1", load_done, load_err);
    end
    checks++;
    if (wq_a.size() != 0) begin errors++; $display("FAIL tmo_nwr: got %0d want 0", wq_a.size()); end
    // Header bytes inside the payload must be taken as data.
    pay = '{32'hA5A5A5A5, $urandom, $urandom};
    send_frame(1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_csum(1'b0);
`endif
    wait_end(seen);
    checks++;
    if (!seen || load_done !== 1'b1 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL tmo_reload: got done=%b hold=%b want 1 0", load_done, cpu_hold);
    end
    checks++;
    if (wq_a.size() != 3) begin errors++; $display("FAIL tmo_nwr2: got %0d want 3", wq_a.size()); end
    for (int i = 0; i < wq_a.size() && i < 3; i++) begin
      checks++;
      if (wq_a[i] !== exp_addr(i) || wq_d[i] !== pay[i]) begin
        errors++;
        $display("FAIL tmo_wr%0d: got %h:%h want %h:%h", i, wq_a[i], wq_d[i], exp_addr(i), pay[i]);
      end
    end
  endtask

  task automatic test_full_frame;
    bit seen;
    int bad = 0;
    pay.delete();
    for (int i = 0; i < DEPTH; i++) pay.push_back($urandom);
    wq_a.delete(); wq_d.delete();
    send_frame(1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_csum(1'b0);
`endif
    wait_end(seen);
    checks++;
    if (!seen || load_done !== 1'b1) begin errors++; $display("FAIL full_done: got %b want 1", load_done); end
    checks++;
    if (words_loaded !== 11'(DEPTH)) begin
      errors++; $display("FAIL full_words: got %0d want %0d", words_loaded, DEPTH);
    end
    checks++;
    if (wq_a.size() != DEPTH) begin
      errors++; $display("FAIL full_nwr: got %0d want %0d", wq_a.size(), DEPTH);
    end
    for (int i = 0; i < wq_a.size() && i < DEPTH; i++) begin
      checks++;
      if (wq_a[i] !== exp_addr(i) || wq_d[i] !== pay[i]) begin
        errors++;
        if (bad++ < 8)
          $display("FAIL full_wr%0d: got %h:%h want %h:%h", i, wq_a[i], wq_d[i], exp_addr(i), pay[i]);
      end
    end
  endtask

  task automatic test_reload_and_reset;
    logic [7:0] part[7];
    send_byte(HDR, 1'b0);
    checks++;
    if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin
      errors++; $display("FAIL reload_hold: got hold=%b done=%b want 1 0", cpu_hold, load_done);
    end
    part = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h77};
    wq_a.delete(); wq_d.delete();
    foreach (part[i]) send_byte(part[i], 1'b0);
    checks++;
    if (words_loaded !== 11'd1) begin errors++; $display("FAIL mid_words: got %0d want 1", words_loaded); end
    #2 in_RST = 1'b1;
    #1;
    checks++;
    if (cpu_hold !== 1'b1 || words_loaded !== '0 || im_we !== 1'b0 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: got hold=%b words=%0d we=%b rdy=%b want 1 0 0 0",
               cpu_hold, words_loaded, im_we, rx_ready);
    end
    @(negedge clk);
    in_RST = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (wq_a.size() != 1) begin errors++; $display("FAIL mid_nwr: got %0d want 1", wq_a.size()); end
    checks++;
    if (wq_d.size() > 0 && wq_d[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL mid_wr0: got %h want deadbeef", wq_d[0]);
    end
    checks++;
    if (load_done !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL mid_after: got done=%b hold=%b want 0 1", load_done, cpu_hold);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef LOADER_CHECKSUM_EN
    test_bad_csum();
`endif
    test_back_to_back();
    test_bad_length();
    test_timeout();
    test_full_frame();
    test_reload_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
